// File: rtl/traffic_light_controller_n.sv
// N-approach junction controller: round-robin GREEN/YELLOW/ALL_RED phases with
// prioritised emergency preemption, pedestrian WALK and warning buzzer outputs.
module traffic_light_controller_n #(
  parameter int N_APPROACH = 4,
  parameter int T_GREEN    = 10,
  parameter int T_YELLOW   = 3,
  parameter int T_ALLRED   = 1,
  parameter int T_EM       = 9,
  parameter int CNT_W      = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [N_APPROACH-1:0]         emergency,
  output logic [2*N_APPROACH-1:0]       lights,
  output logic [N_APPROACH-1:0]         walk,
  output logic [N_APPROACH-1:0]         buzzer,
  output logic                          em_active,
  output logic [$clog2(N_APPROACH)-1:0] em_id
);

  localparam int ID_W = $clog2(N_APPROACH);
  localparam logic [CNT_W-1:0] TG = CNT_W'(T_GREEN);
  localparam logic [CNT_W-1:0] TY = CNT_W'(T_YELLOW);
  localparam logic [CNT_W-1:0] TA = CNT_W'(T_ALLRED);
  localparam logic [CNT_W-1:0] TE = CNT_W'(T_EM);

  typedef enum logic [1:0] {S_GREEN, S_YELLOW, S_ALLRED, S_EM} state_t;

  state_t            state_reg, state_next;
  logic [ID_W-1:0]   cur_reg, cur_next;
  logic [ID_W-1:0]   nxt_reg, nxt_next;
  logic [CNT_W-1:0]  timer_reg, timer_next;
  logic [N_APPROACH-1:0] pend_reg, pend_next;
  logic              em_exit_reg, em_exit_next;

  logic [N_APPROACH-1:0] em_mask, pend_eff;
  logic [ID_W-1:0]   sel;
  logic              any_pend, higher, timer_done;
  logic [CNT_W-1:0]  timer_dec;

  logic [2*N_APPROACH-1:0] lights_next;
  logic [N_APPROACH-1:0]   walk_next, buzzer_next;
  logic                    em_active_next;
  logic [ID_W-1:0]         em_id_next;

  function automatic logic [ID_W-1:0] inc_phase(input logic [ID_W-1:0] p);
    return (p == ID_W'(N_APPROACH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    // While serving k, emergency[k] only extends the hold and never re-arms pend[k].
    em_mask = '0;
    if (state_reg == S_EM) em_mask[cur_reg] = 1'b1;
    pend_eff = pend_reg | (emergency & ~em_mask);

    sel    = '0;
    higher = 1'b0;
    for (int i = 0; i < N_APPROACH; i++) begin
      if (pend_eff[i]) sel = ID_W'(i);
      if (pend_eff[i] && (ID_W'(i) > cur_reg)) higher = 1'b1;
    end
    any_pend = |pend_eff;

    timer_done = (timer_reg <= 1);
    timer_dec  = (timer_reg > 1) ? timer_reg - 1'b1 : timer_reg;

    state_next   = state_reg;
    cur_next     = cur_reg;
    nxt_next     = nxt_reg;
    timer_next   = timer_dec;
    pend_next    = pend_eff;
    em_exit_next = em_exit_reg;

    case (state_reg)
      S_GREEN: begin
        if (any_pend && (sel == cur_reg)) begin
          state_next     = S_EM;
          timer_next     = TE;
          pend_next[sel] = 1'b0;
        end else if (any_pend || timer_done) begin
          state_next   = S_YELLOW;
          timer_next   = TY;
          em_exit_next = 1'b0;
        end
      end
      S_YELLOW: begin
        if (timer_done) begin
          state_next = S_ALLRED;
          timer_next = TA;
        end
      end
      S_ALLRED: begin
        if (timer_done) begin
          if (any_pend) begin
            state_next     = S_EM;
            cur_next       = sel;
            nxt_next       = inc_phase(sel);
            timer_next     = TE;
            pend_next[sel] = 1'b0;
          end else begin
            state_next = S_GREEN;
            cur_next   = nxt_reg;
            nxt_next   = inc_phase(nxt_reg);
            timer_next = TG;
          end
        end
      end
      default: begin
        // Timer saturates at 1 here, marking the minimum hold as satisfied.
        if (higher || (timer_done && !emergency[cur_reg])) begin
          state_next   = S_YELLOW;
          timer_next   = TY;
          em_exit_next = 1'b1;
        end
      end
    endcase
  end

  // Outputs are decoded from the next state so they register alongside it.
  genvar gi;
  generate
    for (gi = 0; gi < N_APPROACH; gi++) begin : g_out
      logic is_cur;
      assign is_cur = (cur_next == ID_W'(gi));
      assign lights_next[2*gi +: 2] =
          (is_cur && (state_next == S_GREEN || state_next == S_EM)) ? 2'b00 :
          (is_cur && state_next == S_YELLOW)                        ? 2'b01 : 2'b10;
      assign walk_next[gi]   = (state_next == S_GREEN) && !is_cur;
      assign buzzer_next[gi] = !is_cur &&
          ((state_next == S_EM) || (state_next == S_YELLOW && !em_exit_next));
    end
  endgenerate

  assign em_active_next = (state_next == S_EM);
  assign em_id_next     = em_active_next ? cur_next : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= S_ALLRED;
      cur_reg     <= '0;
      nxt_reg     <= '0;
      timer_reg   <= TA;
      pend_reg    <= '0;
      em_exit_reg <= 1'b0;
      lights      <= {N_APPROACH{2'b10}};
      walk        <= '0;
      buzzer      <= '0;
      em_active   <= 1'b0;
      em_id       <= '0;
    end else begin
      state_reg   <= state_next;
      cur_reg     <= cur_next;
      nxt_reg     <= nxt_next;
      timer_reg   <= timer_next;
      pend_reg    <= pend_next;
      em_exit_reg <= em_exit_next;
      lights      <= lights_next;
      walk        <= walk_next;
      buzzer      <= buzzer_next;
      em_active   <= em_active_next;
      em_id       <= em_id_next;
    end
  end

endmodule

// File: tb/tb_traffic_light_controller_n.sv
// Directed bench for traffic_light_controller_n with default parameters (N=4).
module tb_traffic_light_controller_n;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] emergency;
  logic [7:0] lights;
  logic [3:0] walk;
  logic [3:0] buzzer;
  logic       em_active;
  logic [1:0] em_id;

  int checks = 0;
  int errors = 0;

  localparam int GREEN = 0, YELLOW = 1, ALLRED = 2, EM = 3, EMY = 4;

  // Hand-written lamp words: approach i green/yellow, all others red (10).
  logic [7:0] g_code [4] = '{8'hA8, 8'hA2, 8'h8A, 8'h2A};
  logic [7:0] y_code [4] = '{8'hA9, 8'hA6, 8'h9A, 8'h6A};
  logic [3:0] others [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

  traffic_light_controller_n dut (
    .clk       (clk),
    .reset     (reset),
    .emergency (emergency),
    .lights    (lights),
    .walk      (walk),
    .buzzer    (buzzer),
    .em_active (em_active),
    .em_id     (em_id)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Check n consecutive cycles of one phase, advancing one clock after each.
  task automatic ph(input string tag, input int mode, input int idx, input int n);
    logic [7:0] exp_l;
    logic [3:0] exp_w, exp_b;
    logic       exp_ea;
    logic [1:0] exp_id;
    exp_w = 4'b0000; exp_b = 4'b0000; exp_ea = 1'b0; exp_id = 2'd0;
    case (mode)
      GREEN:   begin exp_l = g_code[idx]; exp_w = others[idx]; end
      YELLOW:  begin exp_l = y_code[idx]; exp_b = others[idx]; end
      ALLRED:  exp_l = 8'hAA;
      EM:      begin exp_l = g_code[idx]; exp_b = others[idx]; exp_ea = 1'b1; exp_id = 2'(idx); end
      default: exp_l = y_code[idx];
    endcase
    $display("phase %s mode %0d approach %0d cycles %0d", tag, mode, idx, n);
    for (int c = 0; c < n; c++) begin
      chk($sformatf("%s.%0d.lights", tag, c), 32'(lights), 32'(exp_l));
      chk($sformatf("%s.%0d.walk", tag, c), 32'(walk), 32'(exp_w));
      if (mode != EMY)
        chk($sformatf("%s.%0d.buzzer", tag, c), 32'(buzzer), 32'(exp_b));
      chk($sformatf("%s.%0d.em_active", tag, c), 32'(em_active), 32'(exp_ea));
      chk($sformatf("%s.%0d.em_id", tag, c), 32'(em_id), 32'(exp_id));
      tick();
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, ".lights"}, 32'(lights), 32'hAA);
    chk({tag, ".walk"}, 32'(walk), 32'h0);
    chk({tag, ".buzzer"}, 32'(buzzer), 32'h0);
    chk({tag, ".em_active"}, 32'(em_active), 32'h0);
    chk({tag, ".em_id"}, 32'(em_id), 32'h0);
  endtask

  initial begin
    reset = 1'b1;
    emergency = 4'b0000;
    tick();
    chk_reset("reset");
    reset = 1'b0;

    // 1: one full 56-cycle rotation, then approach 0 again
    ph("t1_ar0", ALLRED, 0, 1);
    ph("t1_g0", GREEN, 0, 10);  ph("t1_y0", YELLOW, 0, 3); ph("t1_ar1", ALLRED, 0, 1);
    ph("t1_g1", GREEN, 1, 10);  ph("t1_y1", YELLOW, 1, 3); ph("t1_ar2", ALLRED, 0, 1);
    ph("t1_g2", GREEN, 2, 10);  ph("t1_y2", YELLOW, 2, 3); ph("t1_ar3", ALLRED, 0, 1);
    ph("t1_g3", GREEN, 3, 10);  ph("t1_y3", YELLOW, 3, 3); ph("t1_ar4", ALLRED, 0, 1);

    // 2: emergency[2] pulsed 2 cycles during approach-0 green
    ph("t2_g0", GREEN, 0, 3);
    emergency = 4'b0100;
    ph("t2_g0last", GREEN, 0, 1);
    ph("t2_y0a", YELLOW, 0, 1);
    emergency = 4'b0000;
    ph("t2_y0b", YELLOW, 0, 2);
    ph("t2_ar", ALLRED, 0, 1);
    ph("t2_em2", EM, 2, 9);
    ph("t2_emy2", EMY, 2, 3);
    ph("t2_ar2", ALLRED, 0, 1);
    ph("t2_g3", GREEN, 3, 10); ph("t2_y3", YELLOW, 3, 3); ph("t2_ar3", ALLRED, 0, 1);
    ph("t2_g0b", GREEN, 0, 10); ph("t2_y0c", YELLOW, 0, 3); ph("t2_ar4", ALLRED, 0, 1);

    // 3: emergency[1] held 15 cycles during approach-1 green
    ph("t3_g1", GREEN, 1, 2);
    emergency = 4'b0010;
    ph("t3_g1last", GREEN, 1, 1);
    ph("t3_em1", EM, 1, 14);
    emergency = 4'b0000;
    ph("t3_em1drop", EM, 1, 1);
    ph("t3_emy1", EMY, 1, 3);
    ph("t3_ar", ALLRED, 0, 1);

    // 4: emergency[1] and [3] together; [3] for 15 cycles, [1] for 5 more
    emergency = 4'b1010;
    ph("t4_g2", GREEN, 2, 1);
    ph("t4_y2", YELLOW, 2, 3);
    ph("t4_ar", ALLRED, 0, 1);
    ph("t4_em3", EM, 3, 10);
    emergency = 4'b0010;
    ph("t4_em3drop", EM, 3, 1);
    ph("t4_emy3", EMY, 3, 3);
    ph("t4_ar3", ALLRED, 0, 1);
    emergency = 4'b0000;
    ph("t4_em1", EM, 1, 9);
    ph("t4_emy1", EMY, 1, 3);
    ph("t4_ar1", ALLRED, 0, 1);

    // 5: [3] during EM(1) ends it early; [0] during EM(3) served afterwards
    emergency = 4'b0010;
    ph("t5_g2", GREEN, 2, 1);
    emergency = 4'b0000;
    ph("t5_y2", YELLOW, 2, 3);
    ph("t5_ar", ALLRED, 0, 1);
    ph("t5_em1", EM, 1, 3);
    emergency = 4'b1000;
    ph("t5_em1c4", EM, 1, 1);
    emergency = 4'b0000;
    ph("t5_emy1", EMY, 1, 3);
    ph("t5_ar1", ALLRED, 0, 1);
    ph("t5_em3a", EM, 3, 1);
    emergency = 4'b0001;
    ph("t5_em3b", EM, 3, 1);
    emergency = 4'b0000;
    ph("t5_em3c", EM, 3, 7);
    ph("t5_emy3", EMY, 3, 3);
    ph("t5_ar3", ALLRED, 0, 1);
    ph("t5_em0", EM, 0, 9);
    ph("t5_emy0", EMY, 0, 3);
    ph("t5_ar0", ALLRED, 0, 1);

    // 6: reset during EM(2) cycle 5 with pend[0] latched
    emergency = 4'b0100;
    ph("t6_g1", GREEN, 1, 1);
    emergency = 4'b0000;
    ph("t6_y1", YELLOW, 1, 3);
    ph("t6_ar", ALLRED, 0, 1);
    ph("t6_em2", EM, 2, 3);
    emergency = 4'b0001;
    ph("t6_em2c4", EM, 2, 1);
    emergency = 4'b0000;
    reset = 1'b1;
    ph("t6_em2c5", EM, 2, 1);
    reset = 1'b0;
    chk_reset("t6_reset");
    ph("t6_ar0", ALLRED, 0, 1);
    ph("t6_g0", GREEN, 0, 10);
    ph("t6_y0", YELLOW, 0, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/traffic_light_controller_n.md
Name: traffic_light_controller_n

Overview:
Parametrised N-approach junction controller. It is the successor of the two-approach T-junction controller and uses the same 1 s system tick. It cycles the approaches round-robin through GREEN→YELLOW→ALL_RED, drives per-approach pedestrian WALK and buzzer outputs, and serves N prioritised emergency requests with a minimum hold and safe handover. It sits at the top of the junction design and drives lamp and buzzer drivers directly.

Parameters:
N_APPROACH, 4, number of approaches (≥2)
T_GREEN, 10, normal green duration in cycles (≥1)
T_YELLOW, 3, yellow duration in cycles (≥1)
T_ALLRED, 1, all-red clearance duration in cycles (≥1)
T_EM, 9, minimum emergency green duration in cycles (≥1)
CNT_W, 8, timer width; every duration must be < 2^CNT_W

Ports:
clk  in  1  system clock, 1 tick = 1 s
reset  in  1  synchronous, active-high reset
emergency  in  N_APPROACH  emergency request per approach; higher index = higher priority
lights  out  2*N_APPROACH  per-approach lamp; bits [2i+1:2i] = approach i; 00 GREEN, 01 YELLOW, 10 RED, 11 never driven
walk  out  N_APPROACH  pedestrian WALK per approach
buzzer  out  N_APPROACH  pedestrian warning buzzer per approach
em_active  out  1  emergency green in progress
em_id  out  clog2(N_APPROACH)  approach served by the current emergency; 0 when em_active=0

Behaviour:
- One clock domain, clk. Reset is synchronous and active-high. All outputs are registered.
- Reset:
  - State = ALL_RED; next phase = 0; timer loaded with T_ALLRED; pend = 0.
  - All lights = RED; walk = 0, buzzer = 0, em_active = 0, em_id = 0.
  - Reset mid-operation aborts any state, including EM, on the same edge.
- State durations: each timed state lasts exactly its duration in cycles, then transitions. After reset is released, ALL_RED lasts T_ALLRED cycles, then approach 0 goes GREEN.
- Normal FSM, per phase g:
  - GREEN: lights[g] = GREEN, all others RED, for T_GREEN cycles.
  - YELLOW: lights[g] = YELLOW for T_YELLOW cycles.
  - ALL_RED: for T_ALLRED cycles, then GREEN for phase (g+1) mod N.
- Pending requests: pend[N-1:0] is sticky.
  - Bit k is set whenever emergency[k]=1 is sampled.
  - Exception: during EM for k, emergency[k] extends the hold instead of setting pend[k].
  - pend[k] clears on the edge EM for k is entered.
  - The selected request is the highest set pend bit.
- Preemption:
  - In GREEN of g with selected k = g: go directly to EM(k) with a fresh T_EM timer and no yellow.
  - In GREEN of g with k ≠ g: go to YELLOW immediately, then ALL_RED, then EM(k).
  - In YELLOW or ALL_RED: complete the current state. At the end of ALL_RED, enter EM(highest pend) instead of the next GREEN.
- EM(k):
  - lights[k] = GREEN, all others RED; em_active = 1, em_id = k.
  - Holds until at least T_EM cycles have elapsed AND emergency[k] = 0.
  - A pend bit j > k present at any time ends EM(k) early, even before T_EM.
  - Exit sequence: YELLOW(k) for T_YELLOW, then ALL_RED for T_ALLRED.
  - After exit, if any pend bit is set, enter EM(highest pend). Otherwise resume GREEN of (k+1) mod N.
  - Lower-priority requests arriving during EM are latched and served afterwards, never dropped.
- walk[i] = 1 iff state is GREEN or EM, lights[i] = RED, and em_active = 0. Consequently walk is always 0 during EM.
- buzzer[i] = 1 iff lights[i] = RED and either (state = normal YELLOW) or (em_active = 1). It warns pedestrians that a crossing is closing or that an emergency vehicle is passing.
- Invariant: at most one approach is non-RED in any cycle.
- Timer saturates; it never wraps.

Test Plan:
1. Reset 1 cycle, then run 60 cycles with defaults. Required:
   - ALL_RED 1 cycle, approach 0 GREEN 10 cycles, YELLOW 3, ALL_RED 1, then approach 1 GREEN.
   - Full rotation = 56 cycles.
   - walk = 1110 during approach-0 GREEN; buzzer = 1110 during approach-0 YELLOW.
2. emergency[2] pulsed 2 cycles while approach 0 is GREEN. Required:
   - Approach 0 YELLOW 3, ALL_RED 1, then approach 2 GREEN exactly 9 cycles with em_active = 1, em_id = 2, walk = 0, buzzer = 1011.
   - Then YELLOW 3, ALL_RED 1, then approach 3 GREEN.
3. emergency[1] held 15 cycles, starting during approach 1 GREEN. Required: approach 1 stays GREEN with no yellow gap until the cycle after the drop, then YELLOW 3, ALL_RED 1, then approach 2 GREEN.
4. emergency[1] and emergency[3] asserted together; [3] dropped after 15 cycles, [1] after a further 5. Required:
   - EM(3) is served first.
   - Then YELLOW 3, ALL_RED 1, then EM(1) for at least T_EM cycles.
   - Then resume at approach 2.
5. emergency[1] pulsed; during EM(1), emergency[3] pulsed at EM cycle 4. Required:
   - EM(1) ends early, then YELLOW 3, ALL_RED 1, then EM(3) 9 cycles.
   - Conversely, a [0] pulse during EM(3) is served after EM(3) exits.
6. reset asserted during EM(2) cycle 5. Required: the next cycle has all lights RED, em_active = 0, pend cleared, and the sequence restarts at approach 0.
